btn_debounce_pulse: RTL and testbench

//  Upstream conditioner for the 6-bit LED count stage. Takes a raw, bouncing push-button

---
 rtl/btn_debounce_pulse_pkg.sv | 21 ++
 rtl/btn_debounce_pulse_sync_2ff.sv | 23 ++
 rtl/btn_debounce_pulse.sv | 119 +++++++++++
 tb/tb_btn_debounce_pulse.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pulse_pkg.sv
// btn_debounce_pulse_pkg: FSM state encoding and counter-width helpers for the button conditioner
package btn_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// btn_debounce_pulse_sync_2ff: 1-bit two-flop synchroniser, async active-low reset to 0
module btn_debounce_pulse_sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s1_q   <= d;
            sync_q <= s1_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronise, debounce and one-shot a push button into a count pulse and a level.
// Define BTN_AUTO_REPEAT_EN to add hold-to-repeat pulses while the button stays pressed.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic level
);

    localparam int            CW       = clog2(max2(DEBOUNCE_CYCLES, 2));
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce_pulse: cycle parameters must be >= 1");
    end

    logic          btn_sync;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d, level_q, level_d;
    logic          cnt_last, press_acc, rel_done, rep_fire;

    btn_debounce_pulse_sync_2ff u_sync_2ff (
        .clock(clock),
        .reset(reset),
        .d    (btn_in),
        .q    (btn_sync)
    );

    assign cnt_last  = cnt_q == CNT_LAST;
    assign press_acc = state_q == PRESS_CHK && btn_sync && cnt_last;
    assign rel_done  = state_q == RELEASE_CHK && !btn_sync && cnt_last;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = clog2(max2(max2(REPEAT_DELAY, REPEAT_PERIOD), 2));

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_arm_q, rep_arm_d, rep_hit;

    // rep_arm_q selects the first-repeat delay versus the steady repeat period
    assign rep_hit  = rep_cnt_q == (rep_arm_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
    assign rep_fire = state_q == HELD && btn_sync && rep_hit;

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        if (press_acc || rel_done) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (state_q == HELD && btn_sync) begin
            rep_cnt_d = rep_hit ? '0 : rep_cnt_q + 1'b1;
            rep_arm_d = rep_arm_q | rep_hit;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = press_acc | rep_fire;
        level_d = press_acc ? 1'b1 : rel_done ? 1'b0 : level_q;
        case (state_q)
            IDLE: begin
                state_d = btn_sync ? PRESS_CHK : IDLE;
                cnt_d   = '0;
            end
            PRESS_CHK: begin
                state_d = !btn_sync ? IDLE : cnt_last ? HELD : PRESS_CHK;
                cnt_d   = cnt_q + CW'(btn_sync && !cnt_last);
            end
            HELD: begin
                state_d = btn_sync ? HELD : RELEASE_CHK;
                cnt_d   = '0;
            end
            RELEASE_CHK: begin
                state_d = btn_sync ? HELD : cnt_last ? IDLE : RELEASE_CHK;
                cnt_d   = cnt_q + CW'(!btn_sync && !cnt_last);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: directed bench for the button conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4
module tb_btn_debounce_pulse;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_in = 1'b0;
    logic pulse, level;

    int   total = 0;
    int   bad = 0;
    int   npulse = 0;
    int   dbl = 0;
    logic prev_p = 1'b0;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .btn_in(btn_in),
        .pulse (pulse),
        .level (level)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (pulse === 1'b1) npulse++;
        if (pulse === 1'b1 && prev_p === 1'b1) dbl++;
        prev_p = pulse;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int   n0;
        logic hi;
        logic exp_p;
        cyc(2);
        check("rst_pulse", pulse, 0);
        check("rst_level", level, 0);
        reset = 1'b1;
        cyc(3);

        // clean press: pulse/level after edge 7, level falls 7 edges after release
        n0 = npulse;
        btn_in = 1'b1;
        cyc(6);
        check("t1_early_pulse", pulse, 0);
        check("t1_early_level", level, 0);
        cyc(1);
        check("t1_pulse", pulse, 1);
        check("t1_level", level, 1);
        cyc(1);
        check("t1_single", pulse, 0);
        cyc(12);
        btn_in = 1'b0;
        cyc(6);
        check("t1_lvl_hold", level, 1);
        cyc(1);
        check("t1_lvl_fall", level, 0);
        check("t1_count", npulse - n0, 1);
        cyc(5);

        // glitch rejected, then FSM proven idle by normal latency
        n0 = npulse;
        hi = 1'b0;
        btn_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn_in = 1'b0;
            cyc(1);
            hi |= level;
        end
        check("t2_level", hi, 0);
        check("t2_pulse", npulse - n0, 0);
        btn_in = 1'b1;
        cyc(6);
        check("t2_idle_early", pulse, 0);
        cyc(1);
        check("t2_idle_pulse", pulse, 1);
        btn_in = 1'b0;
        cyc(10);

        // release bounce keeps level high, no extra pulse
        n0 = npulse;
        btn_in = 1'b1;
        cyc(8);
        for (int i = 0; i < 12; i++) begin
            btn_in = (i >= 2);
            cyc(1);
            check($sformatf("t3_level_%0d", i), level, 1);
        end
        check("t3_count", npulse - n0, 1);
        btn_in = 1'b0;
        cyc(10);
        check("t3_release", level, 0);

        // reset during PRESS_CHK, then reset while HELD with button still pressed
        n0 = npulse;
        btn_in = 1'b1;
        cyc(5);
        #2 reset = 1'b0;
        #1;
        check("t4_rst_pulse", pulse, 0);
        check("t4_rst_level", level, 0);
        cyc(2);
        check("t4_abandon", npulse - n0, 0);
        reset = 1'b1;
        cyc(6);
        check("t4_early", pulse, 0);
        cyc(1);
        check("t4_pulse", pulse, 1);
        check("t4_level", level, 1);
        cyc(3);
        #2 reset = 1'b0;
        #1;
        check("t4_held_rst_lvl", level, 0);
        cyc(2);
        reset = 1'b1;
        cyc(6);
        check("t4_held_early", pulse, 0);
        cyc(1);
        check("t4_held_pulse", pulse, 1);
        check("t4_count", npulse - n0, 2);
        btn_in = 1'b0;
        cyc(10);

        // ten presses into a 6-bit LED counter
        n0 = npulse;
        for (int i = 0; i < 10; i++) begin
            btn_in = 1'b1;
            cyc(10);
            btn_in = 1'b0;
            cyc(10);
        end
        check("t5_led", 6'(npulse - n0), 10);

        // long hold: single pulse, or auto-repeat at P, P+8, P+12, ... when enabled
        btn_in = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            cyc(1);
`ifdef BTN_AUTO_REPEAT_EN
            exp_p = (k == 7) || (k >= 15 && k <= 39 && (k - 15) % 4 == 0);
`else
            exp_p = (k == 7);
`endif
            check($sformatf("t6_pulse_e%0d", k), pulse, exp_p);
            if (k == 40) btn_in = 1'b0;
        end
        check("t6_level", level, 0);
        check("no_double", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
